// File: rtl/writeback_stage_pkg.sv
// Shared types for the writeback stage: the memory-stage trunk, the MEM/WB
// register contents and the result-select encoding.
package writeback_stage_pkg;

    localparam int WB_XLEN = 32;
    localparam int REG_AW  = 5;

    localparam logic [REG_AW-1:0] REG_X0 = '0;

    typedef enum logic [1:0] {
        RES_ALU = 2'b00,
        RES_MEM = 2'b01,
        RES_PC4 = 2'b10
    } result_sel_t;

    typedef struct packed {
        logic [WB_XLEN-1:0] ALUResult;
        logic [WB_XLEN-1:0] ReadData;
        logic [WB_XLEN-1:0] PC4;
        logic [REG_AW-1:0]  A3;
        logic               RegW;
        result_sel_t        ResultSelect;
    } Memory_Bundle;

    typedef struct packed {
        logic         valid;
        Memory_Bundle mb;
    } WB_Bundle;

    // The unused 2'b11 encoding yields zero rather than an arbitrary source.
    function automatic logic [WB_XLEN-1:0] select_result(input Memory_Bundle b);
        logic [WB_XLEN-1:0] r;
        r = '0;
        case (b.ResultSelect)
            RES_ALU: r = b.ALUResult;
            RES_MEM: r = b.ReadData;
            RES_PC4: r = b.PC4;
            default: r = '0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/writeback_stage_reg_file.sv
// 2-read / 1-write register file with write-first bypass, hard-zero x0 and
// asynchronous active-low clear of every entry.
module writeback_stage_reg_file #(
    parameter int XLEN  = 32,
    parameter int NREGS = 32,
    parameter int AW    = $clog2(NREGS)
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic [AW-1:0]   ra1_i,
    input  logic [AW-1:0]   ra2_i,
    output logic [XLEN-1:0] rd1_o,
    output logic [XLEN-1:0] rd2_o,
    input  logic            we_i,
    input  logic [AW-1:0]   waddr_i,
    input  logic [XLEN-1:0] wdata_i
);

    logic [XLEN-1:0] mem_q [NREGS];

    // Entry 0 is cleared by reset and never written, so it stays zero.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < NREGS; i++) begin
                mem_q[i] <= '0;
            end
        end else if (we_i && (waddr_i != '0)) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    always_comb begin
        rd1_o = '0;
        if (ra1_i != '0) begin
            if (we_i && (waddr_i == ra1_i)) rd1_o = wdata_i;
            else                            rd1_o = mem_q[ra1_i];
        end
    end

    always_comb begin
        rd2_o = '0;
        if (ra2_i != '0) begin
            if (we_i && (waddr_i == ra2_i)) rd2_o = wdata_i;
            else                            rd2_o = mem_q[ra2_i];
        end
    end

endmodule

// File: rtl/writeback_stage.sv
// Writeback stage: MEM/WB register, result select, register file and an
// optional retired-instruction counter enabled by WB_INSTRET_EN.
module writeback_stage
    import writeback_stage_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int NREGS = 32
) (
    input  logic                     clk,
    input  logic                     reset,
    input  Memory_Bundle             MB,
    input  logic                     mb_valid,
    input  logic                     stall,
    input  logic                     flush,
    input  logic [$clog2(NREGS)-1:0] ra1,
    input  logic [$clog2(NREGS)-1:0] ra2,
    output logic [XLEN-1:0]          rd1,
    output logic [XLEN-1:0]          rd2,
    output logic                     rf_we,
    output logic [$clog2(NREGS)-1:0] rf_waddr,
    output logic [XLEN-1:0]          rf_wdata,
    output logic [63:0]              instret
);

    WB_Bundle           wb_q, wb_d;
    logic [XLEN-1:0]    result;

    // Flush wins over stall; a bubble clears every field, not just valid.
    always_comb begin
        wb_d = wb_q;
        if (flush) begin
            wb_d = '0;
        end else if (!stall) begin
            wb_d.valid = mb_valid;
            wb_d.mb    = MB;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) wb_q <= '0;
        else        wb_q <= wb_d;
    end

    assign result   = select_result(wb_q.mb);
    assign rf_we    = wb_q.valid & wb_q.mb.RegW & (wb_q.mb.A3 != REG_X0);
    assign rf_waddr = rf_we ? wb_q.mb.A3 : '0;
    assign rf_wdata = rf_we ? result : '0;

    writeback_stage_reg_file #(
        .XLEN  (XLEN),
        .NREGS (NREGS)
    ) u_reg_file (
        .clk_i   (clk),
        .rst_ni  (reset),
        .ra1_i   (ra1),
        .ra2_i   (ra2),
        .rd1_o   (rd1),
        .rd2_o   (rd2),
        .we_i    (rf_we),
        .waddr_i (rf_waddr),
        .wdata_i (rf_wdata)
    );

`ifdef WB_INSTRET_EN
    logic [63:0] instret_q, instret_d;
    logic        retire;

    // A held instruction retires only on the edge where it leaves WB.
    assign retire = wb_q.valid & (~stall | flush);

    always_comb begin
        instret_d = instret_q;
        if (retire) instret_d = instret_q + 64'd1;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) instret_q <= '0;
        else        instret_q <= instret_d;
    end

    assign instret = instret_q;
`else
    assign instret = 64'b0;
`endif

endmodule

// File: tb/tb_writeback_stage.sv
// Directed bench for writeback_stage: vector table plus stall/flush/reset sequences.
module tb_writeback_stage;
    import writeback_stage_pkg::*;

    logic         clk;
    logic         reset;
    Memory_Bundle MB;
    logic         mb_valid, stall, flush;
    logic [4:0]   ra1, ra2;
    logic [31:0]  rd1, rd2;
    logic         rf_we;
    logic [4:0]   rf_waddr;
    logic [31:0]  rf_wdata;
    logic [63:0]  instret;

    int n_total;
    int n_pass;

    writeback_stage dut (
        .clk      (clk),
        .reset    (reset),
        .MB       (MB),
        .mb_valid (mb_valid),
        .stall    (stall),
        .flush    (flush),
        .ra1      (ra1),
        .ra2      (ra2),
        .rd1      (rd1),
        .rd2      (rd2),
        .rf_we    (rf_we),
        .rf_waddr (rf_waddr),
        .rf_wdata (rf_wdata),
        .instret  (instret)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        Memory_Bundle mb;
        logic         valid;
        logic         flush;
        logic [4:0]   ra1;
        logic [4:0]   ra2;
        logic         exp_we;
        logic [4:0]   exp_waddr;
        logic [31:0]  exp_wdata;
        logic [31:0]  exp_rd1;
        logic [31:0]  exp_rd2;
        logic [63:0]  exp_ir;
    } vec_t;

    vec_t vecs[9];

    function automatic Memory_Bundle mkmb(input logic [1:0] sel, input logic regw,
                                          input logic [4:0] a3, input logic [31:0] alu,
                                          input logic [31:0] rdata, input logic [31:0] pc4);
        Memory_Bundle b;
        b.ResultSelect = result_sel_t'(sel);
        b.RegW         = regw;
        b.A3           = a3;
        b.ALUResult    = alu;
        b.ReadData     = rdata;
        b.PC4          = pc4;
        return b;
    endfunction

    function automatic vec_t mkv(input Memory_Bundle b, input logic v, input logic f,
                                 input logic [4:0] r1, input logic [4:0] r2,
                                 input logic we, input logic [4:0] wa, input logic [31:0] wd,
                                 input logic [31:0] e1, input logic [31:0] e2,
                                 input logic [63:0] ir);
        vec_t t;
        t.mb = b; t.valid = v; t.flush = f; t.ra1 = r1; t.ra2 = r2;
        t.exp_we = we; t.exp_waddr = wa; t.exp_wdata = wd;
        t.exp_rd1 = e1; t.exp_rd2 = e2; t.exp_ir = ir;
        return t;
    endfunction

    // Expected counter value depends on whether the counter is built in.
    function automatic logic [63:0] ir_exp(input logic [63:0] n);
`ifdef WB_INSTRET_EN
        return n;
`else
        return (n & 64'd0);
`endif
    endfunction

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_rf(input string tag, input logic we, input logic [4:0] wa,
                            input logic [31:0] wd);
        check({tag, ".rf_we"}, {63'd0, rf_we}, {63'd0, we});
        check({tag, ".rf_waddr"}, {59'd0, rf_waddr}, {59'd0, wa});
        check({tag, ".rf_wdata"}, {32'd0, rf_wdata}, {32'd0, wd});
    endtask

    initial begin
        n_total = 0;
        n_pass  = 0;

        vecs[0] = mkv(mkmb(2'b00, 1, 5'd5, 32'h1234, 32'h0, 32'h0), 1, 0, 5'd5, 5'd0,
                      1, 5'd5, 32'h1234, 32'h1234, 32'h0, 64'd0);
        vecs[1] = mkv(mkmb(2'b01, 1, 5'd7, 32'h100, 32'hFFFF_FF80, 32'h8), 1, 0, 5'd5, 5'd7,
                      1, 5'd7, 32'hFFFF_FF80, 32'h1234, 32'hFFFF_FF80, 64'd1);
        vecs[2] = mkv(mkmb(2'b10, 1, 5'd1, 32'h8, 32'h3, 32'h104), 1, 0, 5'd7, 5'd1,
                      1, 5'd1, 32'h104, 32'hFFFF_FF80, 32'h104, 64'd2);
        vecs[3] = mkv(mkmb(2'b00, 1, 5'd0, 32'hDEAD, 32'h0, 32'h0), 1, 0, 5'd0, 5'd1,
                      0, 5'd0, 32'h0, 32'h0, 32'h104, 64'd3);
        vecs[4] = mkv(mkmb(2'b00, 0, 5'd6, 32'h77, 32'h0, 32'h0), 1, 0, 5'd6, 5'd7,
                      0, 5'd0, 32'h0, 32'h0, 32'hFFFF_FF80, 64'd4);
        vecs[5] = mkv(mkmb(2'b00, 1, 5'd8, 32'h99, 32'h0, 32'h0), 0, 0, 5'd8, 5'd5,
                      0, 5'd0, 32'h0, 32'h0, 32'h1234, 64'd5);
        vecs[6] = mkv(mkmb(2'b11, 1, 5'd10, 32'h11, 32'h22, 32'h33), 1, 0, 5'd10, 5'd1,
                      1, 5'd10, 32'h0, 32'h0, 32'h104, 64'd5);
        vecs[7] = mkv(mkmb(2'b00, 1, 5'd12, 32'h4242, 32'h0, 32'h0), 1, 1, 5'd12, 5'd0,
                      0, 5'd0, 32'h0, 32'h0, 32'h0, 64'd6);
        vecs[8] = mkv(mkmb(2'b00, 1, 5'd3, 32'h55, 32'h0, 32'h0), 1, 0, 5'd3, 5'd5,
                      1, 5'd3, 32'h55, 32'h55, 32'h1234, 64'd6);

        reset = 1'b0; MB = '0; mb_valid = 0; stall = 0; flush = 0; ra1 = 5'd5; ra2 = 5'd1;
        #2;
        check_rf("reset", 0, 5'd0, 32'h0);
        check("reset.rd1", {32'd0, rd1}, 64'd0);
        check("reset.rd2", {32'd0, rd2}, 64'd0);
        check("reset.instret", instret, 64'd0);
        @(posedge clk);
        #1 reset = 1'b1;

        for (int i = 0; i < 9; i++) begin
            MB = vecs[i].mb; mb_valid = vecs[i].valid; flush = vecs[i].flush;
            ra1 = vecs[i].ra1; ra2 = vecs[i].ra2; stall = 0;
            tick();
            check_rf($sformatf("vec%0d", i), vecs[i].exp_we, vecs[i].exp_waddr, vecs[i].exp_wdata);
            check($sformatf("vec%0d.rd1", i), {32'd0, rd1}, {32'd0, vecs[i].exp_rd1});
            check($sformatf("vec%0d.rd2", i), {32'd0, rd2}, {32'd0, vecs[i].exp_rd2});
            check($sformatf("vec%0d.instret", i), instret, ir_exp(vecs[i].exp_ir));
        end
        flush = 0;

        // Stall holds A3=9 for three cycles while MB changes underneath.
        MB = mkmb(2'b00, 1, 5'd9, 32'hAA, 32'h0, 32'h0); mb_valid = 1; ra1 = 5'd9; ra2 = 5'd3;
        tick();
        check_rf("stall_load", 1, 5'd9, 32'hAA);
        check("stall_load.instret", instret, ir_exp(64'd7));
        MB = mkmb(2'b00, 1, 5'd13, 32'hBB, 32'h0, 32'h0); stall = 1;
        for (int c = 0; c < 3; c++) begin
            tick();
            check_rf($sformatf("stall%0d", c), 1, 5'd9, 32'hAA);
            check($sformatf("stall%0d.rd1", c), {32'd0, rd1}, 64'hAA);
            check($sformatf("stall%0d.instret", c), instret, ir_exp(64'd7));
        end
        stall = 0; mb_valid = 0;
        tick();
        check_rf("unstall", 0, 5'd0, 32'h0);
        check("unstall.rd1", {32'd0, rd1}, 64'hAA);
        check("unstall.instret", instret, ir_exp(64'd8));

        // Stall together with flush still loads a bubble.
        MB = mkmb(2'b00, 1, 5'd14, 32'hCC, 32'h0, 32'h0); mb_valid = 1;
        tick();
        check_rf("pre_flush", 1, 5'd14, 32'hCC);
        MB = mkmb(2'b00, 1, 5'd15, 32'hDD, 32'h0, 32'h0); stall = 1; flush = 1;
        tick();
        check_rf("stall_flush", 0, 5'd0, 32'h0);
        stall = 0; flush = 0;

        // x3 is written, then reset lands while x4 is in flight.
        MB = mkmb(2'b00, 1, 5'd3, 32'h55, 32'h0, 32'h0); mb_valid = 1; ra1 = 5'd3; ra2 = 5'd4;
        tick();
        mb_valid = 0;
        tick();
        check("x3_stored.rd1", {32'd0, rd1}, 64'h55);
        MB = mkmb(2'b00, 1, 5'd4, 32'h77, 32'h0, 32'h0); mb_valid = 1;
        tick();
        check_rf("inflight", 1, 5'd4, 32'h77);
        reset = 1'b0;
        #1;
        check_rf("midreset", 0, 5'd0, 32'h0);
        check("midreset.rd1", {32'd0, rd1}, 64'd0);
        check("midreset.rd2", {32'd0, rd2}, 64'd0);
        check("midreset.instret", instret, 64'd0);
        mb_valid = 0;
        tick();
        reset = 1'b1;
        tick();
        check("postreset.rd1", {32'd0, rd1}, 64'd0);
        check("postreset.rd2", {32'd0, rd2}, 64'd0);
        check("postreset.instret", instret, 64'd0);
        check_rf("postreset", 0, 5'd0, 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
